bgpu_reset_sequencer: RTL and testbench



---
 rtl/bgpu_reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bgpu_reset_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bgpu_reset_sequencer.sv
// BGPU clock/reset sequencer: pulses the PLL reset, qualifies lock, then releases per-domain resets in order.
// Optional RESET_SEQ_LOCK_TIMEOUT_EN: re-reset the PLL when lock never arrives and count the retries.
module bgpu_reset_sequencer #(
    parameter int NumDomains        = 2,
    parameter int CntWidth          = 16,
    parameter int PllResetCycles    = 8,
    parameter int LockStableCycles  = 64,
    parameter int ReleaseGapCycles  = 16,
    parameter int LockTimeoutCycles = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_locked_i,
    input  logic                  sw_reset_req_i,
    output logic                  pll_reset_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  ready_o,
    output logic [2:0]            state_o,
    output logic                  lock_lost_o,
    output logic [7:0]            retries_o
);

    // state     | meaning
    // PLL_RESET | pll_reset_o held high for PllResetCycles
    // WAIT_LOCK | waiting for synchronized lock
    // STABLE    | lock must hold for LockStableCycles in a row
    // RELEASE   | domain resets released one by one, ReleaseGapCycles apart
    // RUN       | all domains out of reset, ready_o high
    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    localparam logic [CntWidth-1:0] PllResetLast = CntWidth'(PllResetCycles - 1);
    localparam logic [CntWidth-1:0] StableLast   = CntWidth'(LockStableCycles - 1);
    localparam logic [CntWidth-1:0] ReleaseLast  = CntWidth'((NumDomains - 1) * ReleaseGapCycles);

    if (NumDomains < 1 || PllResetCycles < 1 || LockStableCycles < 1 || ReleaseGapCycles < 1
        || LockTimeoutCycles < 1
        || longint'(PllResetCycles) >= (longint'(1) << CntWidth)
        || longint'(LockStableCycles) >= (longint'(1) << CntWidth)
        || longint'(LockTimeoutCycles) >= (longint'(1) << CntWidth)
        || longint'(NumDomains - 1) * longint'(ReleaseGapCycles) >= (longint'(1) << CntWidth))
    begin : g_param_check
        $error("bgpu_reset_sequencer: cycle parameters out of range for CntWidth");
    end

    logic [1:0]            lock_sync_q;
    logic                  lock_s;
    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  pll_reset_q, pll_reset_d;
    logic [NumDomains-1:0] dom_q, dom_d;
    logic                  ready_q, ready_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [31:0]           rel_pos;

    assign lock_s  = lock_sync_q[1];
    assign rel_pos = 32'(cnt_q) + 32'd1;

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(LockTimeoutCycles - 1);
    logic       timeout_hit;
    logic [7:0] retries_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            dom_q       <= dom_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntWidth'(1);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        unique case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == PllResetLast) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    state_d     = S_PLL_RESET;
                    cnt_d       = '0;
                    timeout_hit = 1'b1;
                end
`else
                else begin
                    cnt_d = '0;
                end
`endif
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE, S_RUN: begin
                // Lock loss outranks a software request: never re-release on an unlocked clock.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_reset_req_i) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (state_q == S_RUN) begin
                    cnt_d = '0;
                end else if (cnt_q == ReleaseLast) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output flop lines up with state_q.
    always_comb begin
        pll_reset_d = (state_d == S_PLL_RESET);
        ready_d     = (state_d == S_RUN);
        lock_lost_d = lock_lost_q | ((state_q == S_RUN) & ~lock_s);
        dom_d       = '0;
        if (state_d == S_RUN) begin
            dom_d = '1;
        end else if (state_d == S_RELEASE) begin
            for (int k = 0; k < NumDomains; k++) begin
                dom_d[k] = (state_q == S_RELEASE) ? (rel_pos >= 32'(k * ReleaseGapCycles))
                                                  : (k == 0);
            end
        end
    end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retries_q <= '0;
        end else if (timeout_hit && retries_q != 8'hFF) begin
            retries_q <= retries_q + 8'd1;
        end
    end
    assign retries_o = retries_q;
`else
    assign retries_o = '0;
`endif

    assign pll_reset_o   = pll_reset_q;
    assign domain_rst_no = dom_q;
    assign ready_o       = ready_q;
    assign state_o       = state_q;
    assign lock_lost_o   = lock_lost_q;

endmodule

// File: tb/tb_bgpu_reset_sequencer.sv
// Directed bench for bgpu_reset_sequencer: vector table for bring-up and sw reset, hand sequences for lock corners.
// Expectations for the lock timeout follow RESET_SEQ_LOCK_TIMEOUT_EN as compiled.
module tb_bgpu_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       sw = 1'b0;
    logic       pll_reset;
    logic [1:0] dom;
    logic       ready;
    logic [2:0] state;
    logic       lock_lost;
    logic [7:0] retries;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       sw;
        logic       lk;
        logic [2:0] st;
        logic       pll;
        logic [1:0] dom;
        logic       rdy;
        logic       ll;
    } vec_t;

    bgpu_reset_sequencer #(
        .NumDomains(2), .CntWidth(16), .PllResetCycles(2), .LockStableCycles(4),
        .ReleaseGapCycles(3), .LockTimeoutCycles(20)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pll_locked_i(locked), .sw_reset_req_i(sw),
        .pll_reset_o(pll_reset), .domain_rst_no(dom), .ready_o(ready), .state_o(state),
        .lock_lost_o(lock_lost), .retries_o(retries)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, input logic l, input logic [2:0] st, input logic p,
                                input logic [1:0] d, input logic r, input logic ll);
        vec_t v;
        v.sw = s; v.lk = l; v.st = st; v.pll = p; v.dom = d; v.rdy = r; v.ll = ll;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input int st, input int p, input int d,
                              input int r, input int ll, input int ret);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".pll_reset"}, int'(pll_reset), p);
        chk({tag, ".domain_rst_n"}, int'(dom), d);
        chk({tag, ".ready"}, int'(ready), r);
        chk({tag, ".lock_lost"}, int'(lock_lost), ll);
        chk({tag, ".retries"}, int'(retries), ret);
    endtask

    // Called at a falling edge; drives inputs, checks after the next rising edge, returns at a falling edge.
    task automatic step(input string tag, input logic s, input logic l, input int st, input int p,
                        input int d, input int r, input int ll);
        sw = s;
        locked = l;
        @(posedge clk);
        #1;
        check_outs(tag, st, p, d, r, ll, 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic l);
        rst = 1'b1;
        sw = 1'b0;
        locked = l;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (state != 3'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".reach_run"}, int'(state == 3'd4), 1);
        @(negedge clk);
    endtask

    task automatic exp_timeout(input int e, output int st, output int p, output int ret);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        logic in_pll;
        in_pll = (e >= 22) && ((e % 22) <= 1);
        st  = in_pll ? 0 : 1;
        p   = in_pll ? 1 : 0;
        ret = (e / 22 > 255) ? 255 : e / 22;
`else
        st  = 1;
        p   = 0;
        ret = 0;
`endif
    endtask

    initial begin
        vec_t tbl[$];
        int est, ep, eret;

        // sw, lk, state, pll, dom, ready, lock_lost
        tbl.push_back(mk(0, 1, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b11, 0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 2'b11, 1, 0));
        tbl.push_back(mk(0, 1, 4, 0, 2'b11, 1, 0));
        tbl.push_back(mk(1, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 2'b11, 0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 2'b11, 1, 0));

        // Nominal bring-up, then sw reset in RUN (second request lands in STABLE and is ignored).
        do_reset(1'b1);
        foreach (tbl[i]) begin
            step($sformatf("nom[%0d]", i), tbl[i].sw, tbl[i].lk, int'(tbl[i].st), int'(tbl[i].pll),
                 int'(tbl[i].dom), int'(tbl[i].rdy), int'(tbl[i].ll));
        end

        // Lock loss in RUN, relock back to RUN with sticky flag.
        step("loss1", 0, 0, 4, 0, 3, 1, 0);
        step("loss2", 0, 0, 4, 0, 3, 1, 0);
        step("loss3", 0, 0, 1, 0, 0, 0, 1);
        step("loss4", 0, 1, 1, 0, 0, 0, 1);
        step("loss5", 0, 1, 1, 0, 0, 0, 1);
        step("loss6", 0, 1, 2, 0, 0, 0, 1);
        step("loss7", 0, 1, 2, 0, 0, 0, 1);
        step("loss8", 0, 1, 2, 0, 0, 0, 1);
        step("loss9", 0, 1, 2, 0, 0, 0, 1);
        step("loss10", 0, 1, 3, 0, 1, 0, 1);
        step("loss11", 0, 1, 3, 0, 1, 0, 1);
        step("loss12", 0, 1, 3, 0, 1, 0, 1);
        step("loss13", 0, 1, 3, 0, 3, 0, 1);
        step("loss14", 0, 1, 4, 0, 3, 1, 1);

        // Asynchronous reset between clock edges clears everything, including the sticky flag.
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 1, 0, 0, 0, 0);

        // Lock glitch in STABLE at count 2, then lock loss during RELEASE (no sticky flag).
        do_reset(1'b1);
        step("gl1", 0, 1, 0, 1, 0, 0, 0);
        step("gl2", 0, 1, 1, 0, 0, 0, 0);
        step("gl3", 0, 1, 2, 0, 0, 0, 0);
        step("gl4", 0, 0, 2, 0, 0, 0, 0);
        step("gl5", 0, 1, 2, 0, 0, 0, 0);
        step("gl6", 0, 1, 1, 0, 0, 0, 0);
        step("gl7", 0, 1, 2, 0, 0, 0, 0);
        step("gl8", 0, 1, 2, 0, 0, 0, 0);
        step("gl9", 0, 1, 2, 0, 0, 0, 0);
        step("gl10", 0, 1, 2, 0, 0, 0, 0);
        step("gl11", 0, 1, 3, 0, 1, 0, 0);
        step("gl12", 0, 0, 3, 0, 1, 0, 0);
        step("gl13", 0, 0, 3, 0, 1, 0, 0);
        step("gl14", 0, 0, 1, 0, 0, 0, 0);

        // sw reset coinciding with lock loss in RUN: lock loss wins.
        do_reset(1'b1);
        wait_run("both");
        step("both1", 0, 0, 4, 0, 3, 1, 0);
        step("both2", 0, 0, 4, 0, 3, 1, 0);
        step("both3", 1, 0, 1, 0, 0, 0, 1);
        step("both4", 0, 0, 1, 0, 0, 0, 1);

        // Lock never arrives: timeout re-reset and retry saturation, or indefinite wait.
        do_reset(1'b0);
        for (int e = 1; e <= 5632; e++) begin
            @(posedge clk);
            #1;
            if (e == 2 || e == 21 || e == 22 || e == 23 || e == 24 || e == 44 || e == 65 ||
                e == 66 || e == 5609 || e == 5610 || e == 5632) begin
                exp_timeout(e, est, ep, eret);
                chk($sformatf("tmo[%0d].state", e), int'(state), est);
                chk($sformatf("tmo[%0d].pll_reset", e), int'(pll_reset), ep);
                chk($sformatf("tmo[%0d].retries", e), int'(retries), eret);
                chk($sformatf("tmo[%0d].domain_rst_n", e), int'(dom), 0);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
